skin_map_pingpong: RTL and testbench
====================================

# skin_map_pingpong

Double-buffered skin-map store and bank scheduler placed between the skin detector and the downstream face-localisation stage. It accepts the detector's 1-bit-per-pixel write stream, steers each frame into one of two internal banks, and hands a completed bank to the reader under a ready/done handshake. If the reader has not released its bank when a new frame completes, that frame is dropped and counted.

## Interface
Parameters:
- ADDR_W, 13, pixel address width; each bank holds 2^ADDR_W bits.
- FRAME_PIXELS, 8192, pixels per frame; legal range 1..2^ADDR_W. The last pixel address is FRAME_PIXELS-1.

Ports:
- iClk  input  1  single clock; all logic is rising-edge.
- iReset_n  input  1  asynchronous, active-low reset.
- iWrreq  input  1  write strobe from the skin detector.
- iWr_addr  input  ADDR_W  write pixel address.
- iWr_data  input  1  skin bit, valid in the same cycle as iWrreq.
- iRd_req  input  1  read strobe from the reader.
- iRd_addr  input  ADDR_W  read pixel address.
- iRd_done  input  1  one-cycle pulse; the reader releases its bank.
- oRd_valid  output  1  read data valid.
- oRd_data  output  1  skin bit read back.
- oFrame_ready  output  1  the reader owns a completed frame.
- oFrame_new  output  1  one-cycle pulse when a new frame is handed to the reader.
- oDrop_cnt  output  8  dropped-frame count; saturates at 255.
- oFrame_cnt  output  8  count of frames handed to the reader; wraps modulo 256.

## Operation
- Storage is two banks of 2^ADDR_W x 1 bit with synchronous read. Bank contents are not reset.
- State registers:
  - wr_bank: the bank being written.
  - rd_bank: always equal to ~wr_bank.
  - FSM with states S_EMPTY (the reader holds no frame) and S_FULL (the reader holds a frame).
- Write path:
  - When iWrreq=1 and iWr_addr < FRAME_PIXELS, iWr_data is written to bank[wr_bank][iWr_addr].
  - When iWr_addr >= FRAME_PIXELS, the write is ignored and does not complete a frame.
- Frame complete: fc = iWrreq && (iWr_addr == FRAME_PIXELS-1). The final pixel is written into the old wr_bank before any swap.
- Transitions:
  - S_EMPTY, fc=1: swap (wr_bank toggles), go to S_FULL, pulse oFrame_new, increment oFrame_cnt.
  - S_EMPTY, iRd_done=1: ignored.
  - S_FULL, iRd_done=1, fc=0: go to S_EMPTY.
  - S_FULL, fc=1, iRd_done=0: drop. No swap, stay in S_FULL, oDrop_cnt increments (saturating). The writer overwrites its own bank with the next frame.
  - S_FULL, fc=1 and iRd_done=1 in the same cycle: the release is processed first. Swap, stay in S_FULL, pulse oFrame_new, increment oFrame_cnt. No drop is counted.
- oFrame_ready equals (state == S_FULL).
- Read path:
  - iRd_req=1 returns bank[rd_bank][iRd_addr] one cycle later, with oRd_valid=1.
  - The read samples the rd_bank value in effect during the iRd_req cycle.
  - A read issued in S_EMPTY still returns valid=1, but the data is unspecified and the reader must not issue it.
  - iRd_addr >= FRAME_PIXELS returns oRd_data=0.
- Reads and writes never touch the same bank, so there is no read/write collision.

## Timing
- Reset values:
  - Registers: wr_bank=0, state=S_EMPTY.
  - Outputs: oRd_valid=0, oRd_data=0, oFrame_ready=0, oFrame_new=0, oDrop_cnt=0, oFrame_cnt=0.
- Reset may be asserted mid-frame. All state returns to reset values immediately (asynchronous). Partial bank contents remain but are never handed over; the next frame restarts at wr_bank=0.
- Write latency: the bit is stored at the iWrreq edge and is readable from the opposite bank only after a swap.
- Swap timing: wr_bank, state, and oFrame_ready update at the edge that samples fc. oFrame_new is high in the cycle after that edge, for exactly one cycle.
- Read latency: exactly 1 cycle, with back-to-back reads at one per cycle.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset then fill: write 8192 pixels with data = addr[0], using FRAME_PIXELS=8192. Required: oFrame_new pulses once; oFrame_ready=1; oFrame_cnt=1. Reads of addr 0..3 return 0,1,0,1 with 1-cycle latency.
- Drop: with the reader never asserting iRd_done, write two more full frames. Required: oDrop_cnt=2, oFrame_cnt=1, and read data is still the first frame's pattern.
- Release and swap: assert iRd_done, then write a frame of all 1s. Required: S_EMPTY then S_FULL; reads return 1; oFrame_cnt=2.
- Simultaneous events: in S_FULL, assert iRd_done in the same cycle as the write to address 8191. Required: oFrame_new pulses, oDrop_cnt unchanged, oFrame_ready stays 1.
- Boundary: with FRAME_PIXELS=100, a write to addr 150 is ignored, and the write to addr 99 completes the frame. Drive 256+ drops and check oDrop_cnt saturates at 255.
- Async reset mid-frame: assert iReset_n=0 between edges after 4000 writes. Required: outputs are 0 immediately, and after reset a fresh full frame produces oFrame_cnt=1.

Source files
------------

// File: rtl/skin_map_pingpong.sv
// rtl/skin_map_pingpong.sv - double-buffered 1-bit skin-map store with reader bank handoff
module skin_map_pingpong #(
  parameter int ADDR_W       = 13,
  parameter int FRAME_PIXELS = 8192
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iWrreq,
  input  logic [ADDR_W-1:0] iWr_addr,
  input  logic              iWr_data,
  input  logic              iRd_req,
  input  logic [ADDR_W-1:0] iRd_addr,
  input  logic              iRd_done,
  output logic              oRd_valid,
  output logic              oRd_data,
  output logic              oFrame_ready,
  output logic              oFrame_new,
  output logic [7:0]        oDrop_cnt,
  output logic [7:0]        oFrame_cnt
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LP_FRAME = (ADDR_W+1)'(FRAME_PIXELS);
  localparam logic [ADDR_W:0] LP_LAST  = (ADDR_W+1)'(FRAME_PIXELS - 1);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_bank0 [DEPTH];
  logic       r_bank1 [DEPTH];
  logic       r_wr_bank;
  logic       w_rd_bank;
  logic       w_wr_en;
  logic       w_fc;
  logic       w_swap;
  logic       w_drop;
  logic       r_rd_valid;
  logic       r_rd_oor;
  logic       r_rd_raw;
  logic       r_frame_new;
  logic [7:0] r_drop_cnt;
  logic [7:0] r_frame_cnt;

  assign w_rd_bank = ~r_wr_bank;
  assign w_wr_en   = iWrreq && ({1'b0, iWr_addr} < LP_FRAME);
  assign w_fc      = iWrreq && ({1'b0, iWr_addr} == LP_LAST);

  // A release arriving with frame-complete is taken first, so that frame is handed over, not dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_fc) begin
          w_swap      = 1'b1;
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (w_fc && iRd_done) begin
          w_swap = 1'b1;
        end else if (w_fc) begin
          w_drop = 1'b1;
        end else if (iRd_done) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state     <= S_EMPTY;
      r_wr_bank   <= 1'b0;
      r_frame_new <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_drop_cnt  <= 8'd0;
      r_rd_valid  <= 1'b0;
      r_rd_oor    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_bank   <= r_wr_bank ^ w_swap;
      r_frame_new <= w_swap;
      r_rd_valid  <= iRd_req;
      r_rd_oor    <= ({1'b0, iRd_addr} >= LP_FRAME);
      if (w_swap) r_frame_cnt <= r_frame_cnt + 8'd1;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Bank storage is deliberately unreset; the reader and writer never share a bank.
  always_ff @(posedge iClk) begin
    if (w_wr_en && !r_wr_bank) r_bank0[iWr_addr] <= iWr_data;
    if (w_wr_en &&  r_wr_bank) r_bank1[iWr_addr] <= iWr_data;
    if (iRd_req) r_rd_raw <= w_rd_bank ? r_bank1[iRd_addr] : r_bank0[iRd_addr];
  end

  assign oRd_valid    = r_rd_valid;
  assign oRd_data     = r_rd_valid & ~r_rd_oor & r_rd_raw;
  assign oFrame_ready = (r_state == S_FULL);
  assign oFrame_new   = r_frame_new;
  assign oDrop_cnt    = r_drop_cnt;
  assign oFrame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_skin_map_pingpong.sv
// tb/tb_skin_map_pingpong.sv - randomized self-checking bench for skin_map_pingpong
module tb_skin_map_pingpong;
  localparam int AW  = 13;
  localparam int FP  = 8192;
  localparam int SFP = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          b_wr, b_wdata, b_rq, b_done, b_rv, b_rd, b_ready, b_new;
  logic [AW-1:0] b_waddr, b_raddr;
  logic [7:0]    b_drop, b_fcnt;
  logic          s_wr, s_wdata, s_rq, s_done, s_rv, s_rd, s_ready, s_new;
  logic [AW-1:0] s_waddr, s_raddr;
  logic [7:0]    s_drop, s_fcnt;

  skin_map_pingpong #(.ADDR_W(AW), .FRAME_PIXELS(FP)) dut (
    .iClk(clk), .iReset_n(rst_n), .iWrreq(b_wr), .iWr_addr(b_waddr), .iWr_data(b_wdata),
    .iRd_req(b_rq), .iRd_addr(b_raddr), .iRd_done(b_done), .oRd_valid(b_rv), .oRd_data(b_rd),
    .oFrame_ready(b_ready), .oFrame_new(b_new), .oDrop_cnt(b_drop), .oFrame_cnt(b_fcnt));

  skin_map_pingpong #(.ADDR_W(AW), .FRAME_PIXELS(SFP)) dut_s (
    .iClk(clk), .iReset_n(rst_n), .iWrreq(s_wr), .iWr_addr(s_waddr), .iWr_data(s_wdata),
    .iRd_req(s_rq), .iRd_addr(s_raddr), .iRd_done(s_done), .oRd_valid(s_rv), .oRd_data(s_rd),
    .oFrame_ready(s_ready), .oFrame_new(s_new), .oDrop_cnt(s_drop), .oFrame_cnt(s_fcnt));

  int checks = 0;
  int errors = 0;

  // Reference model: the frame the reader holds, the frame being assembled, and the counters.
  bit held [FP];
  bit wbuf [FP];
  bit tmp  [FP];
  bit m_full;
  bit m_new;
  int m_fcnt;
  int m_drop;
  bit exp_rd_known;
  bit exp_rd;

  task automatic model_reset();
    m_full = 0; m_new = 0; m_fcnt = 0; m_drop = 0;
  endtask

  task automatic big_cycle(input bit wr, input int addr, input bit d, input bit rq, input int raddr, input bit done);
    bit fc;
    b_wr = wr; b_waddr = addr[AW-1:0]; b_wdata = d;
    b_rq = rq; b_raddr = raddr[AW-1:0]; b_done = done;
    exp_rd_known = rq && m_full;
    exp_rd = held[raddr];
    @(posedge clk); #1;
    if (wr && addr < FP) wbuf[addr] = d;
    fc = wr && (addr == FP - 1);
    m_new = 0;
    if (fc && (!m_full || done)) begin
      tmp = held; held = wbuf; wbuf = tmp;
      m_full = 1; m_fcnt = (m_fcnt + 1) % 256; m_new = 1;
    end else if (fc) begin
      if (m_drop < 255) m_drop = m_drop + 1;
    end else if (done) begin
      m_full = 0;
    end
  endtask

  task automatic write_frame(input int mode, input bit done_last, output int pulses, output int new_err, output int rdy_err);
    bit d;
    pulses = 0; new_err = 0; rdy_err = 0;
    for (int a = 0; a <= FP; a++) begin
      d = (mode == 0) ? a[0] : (mode == 1) ? 1'b1 : 1'($urandom);
      if (a < FP) big_cycle(1, a, d, 0, 0, done_last && (a == FP - 1));
      else        big_cycle(0, 0, 0, 0, 0, 0);
      if (b_new === 1'b1) pulses++;
      if (b_new !== m_new) new_err++;
      if (b_ready !== m_full) rdy_err++;
    end
  endtask

  task automatic read_rand(input int n, output int errs);
    int ra;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      ra = $urandom_range(FP - 1, 0);
      big_cycle(0, 0, 0, 1, ra, 0);
      if (exp_rd_known && (b_rv !== 1'b1 || b_rd !== exp_rd)) errs++;
    end
  endtask

  task automatic small_cycle(input bit wr, input int addr, input bit d, input bit rq, input int raddr);
    s_wr = wr; s_waddr = addr[AW-1:0]; s_wdata = d;
    s_rq = rq; s_raddr = raddr[AW-1:0]; s_done = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    b_wr = 0; b_waddr = '0; b_wdata = 0; b_rq = 0; b_raddr = '0; b_done = 0;
    s_wr = 0; s_waddr = '0; s_wdata = 0; s_rq = 0; s_raddr = '0; s_done = 0;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({b_rv, b_rd, b_ready, b_new, b_drop, b_fcnt} !== 20'd0) begin errors++; $display("FAIL reset_big: got %h want 0", {b_rv, b_rd, b_ready, b_new, b_drop, b_fcnt}); end
    checks++; if ({s_rv, s_rd, s_ready, s_new, s_drop, s_fcnt} !== 20'd0) begin errors++; $display("FAIL reset_small: got %h want 0", {s_rv, s_rd, s_ready, s_new, s_drop, s_fcnt}); end
    rst_n = 1;
  endtask

  task automatic test_fill();
    int p, ne, re, errs;
    write_frame(0, 0, p, ne, re);
    checks++; if (p != 1) begin errors++; $display("FAIL fill_new_pulses: got %0d want 1", p); end
    checks++; if (ne != 0) begin errors++; $display("FAIL fill_new_timing: got %0d bad cycles want 0", ne); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL fill_ready: got %b want 1", b_ready); end
    checks++; if (b_fcnt !== 8'd1) begin errors++; $display("FAIL fill_frame_cnt: got %0d want 1", b_fcnt); end
    checks++; if (b_rv !== 1'b0) begin errors++; $display("FAIL fill_idle_valid: got %b want 0", b_rv); end
    for (int i = 0; i < 4; i++) begin
      big_cycle(0, 0, 0, 1, i, 0);
      checks++; if (b_rv !== 1'b1 || b_rd !== i[0]) begin errors++; $display("FAIL fill_read%0d: got v=%b d=%b want v=1 d=%b", i, b_rv, b_rd, i[0]); end
    end
    read_rand(40, errs);
    checks++; if (errs != 0) begin errors++; $display("FAIL fill_read_rand: got %0d mismatches want 0", errs); end
  endtask

  task automatic test_drop();
    int p, ne, re, errs, pt;
    pt = 0;
    for (int f = 0; f < 2; f++) begin
      write_frame(2, 0, p, ne, re);
      pt += p;
    end
    checks++; if (pt != 0) begin errors++; $display("FAIL drop_new_pulses: got %0d want 0", pt); end
    checks++; if (b_drop !== 8'd2) begin errors++; $display("FAIL drop_cnt: got %0d want 2", b_drop); end
    checks++; if (b_fcnt !== 8'd1) begin errors++; $display("FAIL drop_frame_cnt: got %0d want 1", b_fcnt); end
    for (int i = 0; i < 4; i++) begin
      big_cycle(0, 0, 0, 1, i, 0);
      checks++; if (b_rd !== i[0]) begin errors++; $display("FAIL drop_read%0d: got %b want %b", i, b_rd, i[0]); end
    end
    read_rand(40, errs);
    checks++; if (errs != 0) begin errors++; $display("FAIL drop_read_rand: got %0d mismatches want 0", errs); end
  endtask

  task automatic test_release();
    int p, ne, re, ones;
    big_cycle(0, 0, 0, 0, 0, 1);
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL release_empty: got %b want 0", b_ready); end
    write_frame(1, 0, p, ne, re);
    checks++; if (p != 1 || ne != 0) begin errors++; $display("FAIL release_new: got pulses=%0d bad=%0d want 1/0", p, ne); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL release_full: got %b want 1", b_ready); end
    checks++; if (b_fcnt !== 8'd2) begin errors++; $display("FAIL release_frame_cnt: got %0d want 2", b_fcnt); end
    ones = 0;
    for (int i = 0; i < 32; i++) begin
      big_cycle(0, 0, 0, 1, $urandom_range(FP - 1, 0), 0);
      if (b_rd === 1'b1) ones++;
    end
    checks++; if (ones != 32) begin errors++; $display("FAIL release_read_ones: got %0d want 32", ones); end
  endtask

  task automatic test_simultaneous();
    int p, ne, re, errs;
    write_frame(2, 1, p, ne, re);
    checks++; if (p != 1 || ne != 0) begin errors++; $display("FAIL simul_new: got pulses=%0d bad=%0d want 1/0", p, ne); end
    checks++; if (re != 0) begin errors++; $display("FAIL simul_ready_stays: got %0d bad cycles want 0", re); end
    checks++; if (b_drop !== 8'd2) begin errors++; $display("FAIL simul_drop: got %0d want 2", b_drop); end
    checks++; if (b_fcnt !== 8'd3) begin errors++; $display("FAIL simul_frame_cnt: got %0d want 3", b_fcnt); end
    read_rand(64, errs);
    checks++; if (errs != 0) begin errors++; $display("FAIL simul_read_rand: got %0d mismatches want 0", errs); end
  endtask

  task automatic test_boundary();
    bit sb [SFP];
    int pulses, errs, ra;
    small_cycle(1, 150, 1, 0, 0);
    small_cycle(0, 0, 0, 0, 0);
    checks++; if (s_ready !== 1'b0 || s_fcnt !== 8'd0) begin errors++; $display("FAIL bound_oor_write: got ready=%b cnt=%0d want 0/0", s_ready, s_fcnt); end
    pulses = 0;
    for (int a = 0; a < SFP; a++) begin
      sb[a] = 1'($urandom);
      small_cycle(1, a, sb[a], 0, 0);
      if (s_new === 1'b1) pulses++;
    end
    checks++; if (s_ready !== 1'b1 || s_fcnt !== 8'd1 || pulses != 1) begin errors++; $display("FAIL bound_complete: got ready=%b cnt=%0d pulses=%0d want 1/1/1", s_ready, s_fcnt, pulses); end
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(SFP - 1, 0);
      small_cycle(0, 0, 0, 1, ra);
      if (s_rv !== 1'b1 || s_rd !== sb[ra]) errs++;
    end
    checks++; if (errs != 0) begin errors++; $display("FAIL bound_read_rand: got %0d mismatches want 0", errs); end
    small_cycle(0, 0, 0, 1, 150);
    checks++; if (s_rv !== 1'b1 || s_rd !== 1'b0) begin errors++; $display("FAIL bound_read_oor: got v=%b d=%b want 1/0", s_rv, s_rd); end
    for (int i = 0; i < 254; i++) small_cycle(1, SFP - 1, ~sb[SFP-1], 0, 0);
    checks++; if (s_drop !== 8'd254) begin errors++; $display("FAIL bound_drop254: got %0d want 254", s_drop); end
    for (int i = 0; i < 6; i++) small_cycle(1, SFP - 1, ~sb[SFP-1], 0, 0);
    checks++; if (s_drop !== 8'd255) begin errors++; $display("FAIL bound_drop_sat: got %0d want 255", s_drop); end
    checks++; if (s_fcnt !== 8'd1 || s_ready !== 1'b1) begin errors++; $display("FAIL bound_after_drops: got cnt=%0d ready=%b want 1/1", s_fcnt, s_ready); end
    small_cycle(0, 0, 0, 1, SFP - 1);
    checks++; if (s_rd !== sb[SFP-1]) begin errors++; $display("FAIL bound_reader_intact: got %b want %b", s_rd, sb[SFP-1]); end
    small_cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    int p, ne, re, errs;
    for (int a = 0; a < 4000; a++) big_cycle(1, a, 1'($urandom), a == 3999, 5, 0);
    checks++; if (b_rv !== 1'b1 || b_ready !== 1'b1 || b_fcnt !== 8'd3) begin errors++; $display("FAIL arst_pre: got v=%b ready=%b cnt=%0d want 1/1/3", b_rv, b_ready, b_fcnt); end
    b_wr = 0; b_rq = 0; b_done = 0;
    #2 rst_n = 0;
    #1;
    checks++; if ({b_rv, b_rd, b_ready, b_new, b_drop, b_fcnt} !== 20'd0) begin errors++; $display("FAIL arst_immediate: got %h want 0", {b_rv, b_rd, b_ready, b_new, b_drop, b_fcnt}); end
    checks++; if ({s_drop, s_fcnt, s_ready} !== 17'd0) begin errors++; $display("FAIL arst_small: got %h want 0", {s_drop, s_fcnt, s_ready}); end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    write_frame(2, 0, p, ne, re);
    checks++; if (p != 1 || ne != 0) begin errors++; $display("FAIL arst_new: got pulses=%0d bad=%0d want 1/0", p, ne); end
    checks++; if (b_fcnt !== 8'd1 || b_ready !== 1'b1 || b_drop !== 8'd0) begin errors++; $display("FAIL arst_fresh: got cnt=%0d ready=%b drop=%0d want 1/1/0", b_fcnt, b_ready, b_drop); end
    read_rand(64, errs);
    checks++; if (errs != 0) begin errors++; $display("FAIL arst_read_rand: got %0d mismatches want 0", errs); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drop();
    test_release();
    test_simultaneous();
    test_boundary();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
